// File: rtl/ss_chunk_sequencer.sv
// Save-state bus initiator: walks one slave's address range, streaming words out (save) or in (restore).
// Optional trailer checksum word is enabled by defining SS_CHECKSUM_EN.
module ss_chunk_sequencer #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 24,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [IDX_W-1:0]  idx,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  ss_idx,
    output logic [ADDR_W-1:0] ss_addr,
    output logic [DATA_W-1:0] ss_wdata,
    output logic              ss_read,
    output logic              ss_write,
    input  logic [DATA_W-1:0] ss_rdata,
    input  logic              ss_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    // Only the idx and count fields of a received header are compared.
    localparam logic [63:0] HDR_MASK = {16'hFFFF, 24'd0, 24'hFF_FFFF};

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_OUT, S_HDR_IN, S_PULL, S_REQ, S_PUSH,
        S_NEXT, S_DONE, S_ERR, S_CSUM_OUT, S_CSUM_IN
    } state_t;

    state_t             state_reg, state_next;
    logic               op_reg, op_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [ADDR_W-1:0]  count_reg, count_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
`ifdef SS_CHECKSUM_EN
    logic [DATA_W-1:0]  csum_reg, csum_next;
`endif

    logic [63:0]        hdr_word;
    logic [63:0]        in_word;
    logic               hdr_match;
    logic [ADDR_W-1:0]  addr_inc;

    assign hdr_word  = {16'(idx_reg), 24'd0, 24'(count_reg)};
    assign in_word   = 64'(in_data);
    assign hdr_match = ((in_word ^ hdr_word) & HDR_MASK) == 64'd0;
    assign addr_inc  = addr_reg + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_reg    <= 1'b0;
            idx_reg   <= '0;
            count_reg <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            timer_reg <= '0;
`ifdef SS_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            timer_reg <= timer_next;
`ifdef SS_CHECKSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        timer_next = timer_reg;
`ifdef SS_CHECKSUM_EN
        csum_next  = csum_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (start) begin
                    if (count == '0) begin
                        state_next = S_ERR;
                    end else begin
                        op_next    = op;
                        idx_next   = idx;
                        count_next = count;
                        addr_next  = '0;
`ifdef SS_CHECKSUM_EN
                        csum_next  = '0;
`endif
                        state_next = op ? S_HDR_IN : S_HDR_OUT;
                    end
                end
            end
            S_HDR_OUT: if (out_ready) state_next = S_REQ;
            S_HDR_IN: begin
                if (in_valid) state_next = hdr_match ? S_PULL : S_ERR;
            end
            S_PULL: begin
                if (in_valid) begin
                    data_next  = in_data;
`ifdef SS_CHECKSUM_EN
                    csum_next  = csum_reg ^ in_data;
`endif
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (ss_ack) begin
                    timer_next = '0;
                    if (op_reg) begin
                        state_next = S_NEXT;
                    end else begin
                        data_next  = ss_rdata;
`ifdef SS_CHECKSUM_EN
                        csum_next  = csum_reg ^ ss_rdata;
`endif
                        state_next = S_PUSH;
                    end
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    // Strobe has now been high TIMEOUT cycles without ack.
                    state_next = S_ERR;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            S_PUSH: if (out_ready) state_next = S_NEXT;
            S_NEXT: begin
                addr_next = addr_inc;
                if (addr_inc == count_reg) begin
`ifdef SS_CHECKSUM_EN
                    state_next = op_reg ? S_CSUM_IN : S_CSUM_OUT;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = op_reg ? S_PULL : S_REQ;
                end
            end
`ifdef SS_CHECKSUM_EN
            S_CSUM_OUT: if (out_ready) state_next = S_DONE;
            S_CSUM_IN: begin
                if (in_valid) state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy     = !(state_reg inside {S_IDLE, S_DONE, S_ERR});
    assign done     = (state_reg == S_DONE);
    assign error    = (state_reg == S_ERR);
    assign ss_idx   = idx_reg;
    assign ss_addr  = addr_reg;
    assign ss_wdata = op_reg ? data_reg : '0;
    assign ss_read  = (state_reg == S_REQ) && !op_reg;
    assign ss_write = (state_reg == S_REQ) && op_reg;
`ifdef SS_CHECKSUM_EN
    assign in_ready  = state_reg inside {S_HDR_IN, S_PULL, S_CSUM_IN};
    assign out_valid = state_reg inside {S_HDR_OUT, S_PUSH, S_CSUM_OUT};
`else
    assign in_ready  = state_reg inside {S_HDR_IN, S_PULL};
    assign out_valid = state_reg inside {S_HDR_OUT, S_PUSH};
`endif

    always_comb begin
        out_data = '0;
        case (state_reg)
            S_HDR_OUT:  out_data = DATA_W'(hdr_word);
            S_PUSH:     out_data = data_reg;
`ifdef SS_CHECKSUM_EN
            S_CSUM_OUT: out_data = csum_reg;
`endif
            default:    out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_ss_chunk_sequencer.sv
// Directed testbench for ss_chunk_sequencer: save, restore, back-pressure, timeout, reset and header errors.
module tb_ss_chunk_sequencer;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 24;
    localparam int IDX_W   = 8;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              op;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] count;
    logic              busy, done, error;
    logic [IDX_W-1:0]  ss_idx;
    logic [ADDR_W-1:0] ss_addr;
    logic [DATA_W-1:0] ss_wdata;
    logic              ss_read, ss_write;
    logic [DATA_W-1:0] ss_rdata;
    logic              ss_ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave / stream models
    bit                slave_en = 1'b1;
    int                ack_delay = 1;
    int                read_rises = 0;
    int                write_rises = 0;
    int                ir_viol = 0;
    logic [ADDR_W-1:0] rd_addr_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [DATA_W-1:0] out_q[$];
    logic [DATA_W-1:0] src_q[$];

    ss_chunk_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .idx(idx), .count(count),
        .busy(busy), .done(done), .error(error),
        .ss_idx(ss_idx), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
        .ss_read(ss_read), .ss_write(ss_write), .ss_rdata(ss_rdata), .ss_ack(ss_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] slave_data(input logic [ADDR_W-1:0] a);
        return 64'hC0DE_0000_0000_0000 | 64'(a) | (64'(a) << 32);
    endfunction

    function automatic logic [63:0] hdr(input logic [IDX_W-1:0] i, input logic [ADDR_W-1:0] c);
        return {16'(i), 24'd0, 24'(c)};
    endfunction

    initial forever @(posedge clk) cyc++;

    // Slave responder, stream sink monitor and in_ready legality monitor.
    initial begin
        logic prev_strobe;
        int   wait_cnt;
        prev_strobe = 1'b0;
        wait_cnt    = 0;
        ss_ack      = 1'b0;
        ss_rdata    = '0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (in_ready && (ss_read || ss_write || out_valid || done || error)) ir_viol++;
            if ((ss_read || ss_write) && !prev_strobe) begin
                if (ss_read) read_rises++;
                else write_rises++;
            end
            prev_strobe = ss_read || ss_write;
            if ((ss_read || ss_write) && slave_en) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    ss_ack   = 1'b1;
                    ss_rdata = slave_data(ss_addr);
                    if (ss_read) rd_addr_q.push_back(ss_addr);
                    else begin
                        wr_addr_q.push_back(ss_addr);
                        wr_data_q.push_back(ss_wdata);
                    end
                    wait_cnt = 0;
                end else begin
                    ss_ack = 1'b0;
                end
            end else begin
                ss_ack   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Restore stream source, presents src_q words in order.
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (src_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
                if (in_ready) begin
                    @(posedge clk);
                    #1;
                    void'(src_q.pop_front());
                    in_valid = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    task automatic do_start(input logic o, input logic [IDX_W-1:0] i, input logic [ADDR_W-1:0] c);
        @(posedge clk); #1;
        start = 1'b1; op = o; idx = i; count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < max_cyc && !got_done && !got_err; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            if (error) got_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; idx = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, ss_read, ss_write, out_valid, in_ready} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b required 0000000", {busy, done, error, ss_read, ss_write, out_valid, in_ready});
            n_fail++;
        end
        n_checks++;
        if ({ss_idx, ss_addr, ss_wdata, out_data} !== '0) begin
            $display("FAIL reset_data: idx=%h addr=%h wdata=%h out=%h required all 0", ss_idx, ss_addr, ss_wdata, out_data);
            n_fail++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_save_basic();
        int ob, rb, rr;
        bit gd, ge;
        logic [63:0] exp_w[$];
        logic [63:0] x;
        ob = out_q.size(); rb = rd_addr_q.size(); rr = read_rises;
        out_ready = 1'b1; slave_en = 1'b1; ack_delay = 1;
        exp_w.push_back(hdr(8'd5, 24'd3));
        x = '0;
        for (int a = 0; a < 3; a++) begin
            exp_w.push_back(slave_data(ADDR_W'(a)));
            x ^= slave_data(ADDR_W'(a));
        end
`ifdef SS_CHECKSUM_EN
        exp_w.push_back(x);
`endif
        do_start(1'b0, 8'd5, 24'd3);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL save_busy: got %b required 1", busy); n_fail++;
        end
        wait_end(200, gd, ge);
        n_checks++;
        if ({gd, ge} !== 2'b10) begin
            $display("FAIL save_done: done=%b error=%b required done=1 error=0", gd, ge); n_fail++;
        end
        n_checks++;
        if (out_q.size() - ob !== exp_w.size()) begin
            $display("FAIL save_wordcount: got %0d required %0d", out_q.size() - ob, exp_w.size()); n_fail++;
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                n_checks++;
                if (out_q[ob + k] !== exp_w[k]) begin
                    $display("FAIL save_word%0d: got %h required %h", k, out_q[ob + k], exp_w[k]); n_fail++;
                end
            end
        end
        n_checks++;
        if (read_rises - rr !== 3) begin
            $display("FAIL save_reads: got %0d required 3", read_rises - rr); n_fail++;
        end
        n_checks++;
        if (rd_addr_q.size() - rb !== 3 || rd_addr_q[rb] !== 24'd0 || rd_addr_q[rb + 1] !== 24'd1 || rd_addr_q[rb + 2] !== 24'd2) begin
            $display("FAIL save_addrs: got %0d reads required addrs 0,1,2", rd_addr_q.size() - rb); n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL save_idle: busy got %b required 0", busy); n_fail++;
        end
        $display("save idx=5 count=3: %0d stream words, %0d reads", out_q.size() - ob, read_rises - rr);
    endtask

    task automatic test_backpressure();
        int ob, r1;
        bit gd, ge, seen, held, noread;
        logic [63:0] d1;
        ob = out_q.size();
        out_ready = 1'b1;
        do_start(1'b0, 8'd2, 24'd3);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_data === slave_data(24'd0)) seen = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        d1 = out_data; r1 = read_rises;
        n_checks++;
        if (d1 !== slave_data(24'd1)) begin
            $display("FAIL bp_word1: got %h required %h", d1, slave_data(24'd1)); n_fail++;
        end
        held = 1'b1; noread = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== d1) held = 1'b0;
            if (read_rises != r1 || ss_read) noread = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1) begin
            $display("FAIL bp_hold: out_valid=%b out_data=%h required 1 and %h", out_valid, out_data, d1); n_fail++;
        end
        n_checks++;
        if (noread !== 1'b1) begin
            $display("FAIL bp_noread: reads during stall %0d required 0", read_rises - r1); n_fail++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_end(100, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || out_q.size() < ob + 4 || out_q[ob + 2] !== slave_data(24'd1) || out_q[ob + 3] !== slave_data(24'd2)) begin
            $display("FAIL bp_finish: done=%b words=%0d required done=1 words>=4 in order", gd, out_q.size() - ob); n_fail++;
        end
        $display("save backpressure: word1 held 10 cycles, %0d stream words", out_q.size() - ob);
    endtask

    task automatic test_restore();
        int wb, wr, iv;
        bit gd, ge;
        wb = wr_addr_q.size(); wr = write_rises; iv = ir_viol;
        src_q.push_back(hdr(8'd5, 24'd2));
        src_q.push_back(64'hA5A5_A5A5_A5A5_A5A5);
        src_q.push_back(64'h5A5A_5A5A_5A5A_5A5A);
`ifdef SS_CHECKSUM_EN
        src_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
`endif
        do_start(1'b1, 8'd5, 24'd2);
        wait_end(200, gd, ge);
        n_checks++;
        if ({gd, ge} !== 2'b10) begin
            $display("FAIL restore_done: done=%b error=%b required done=1 error=0", gd, ge); n_fail++;
        end
        n_checks++;
        if (write_rises - wr !== 2 || wr_addr_q.size() - wb !== 2) begin
            $display("FAIL restore_writes: got %0d strobes required 2", write_rises - wr); n_fail++;
        end else begin
            n_checks++;
            if (wr_addr_q[wb] !== 24'd0 || wr_data_q[wb] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
                $display("FAIL restore_w0: addr=%h data=%h required 0 a5a5a5a5a5a5a5a5", wr_addr_q[wb], wr_data_q[wb]); n_fail++;
            end
            n_checks++;
            if (wr_addr_q[wb + 1] !== 24'd1 || wr_data_q[wb + 1] !== 64'h5A5A_5A5A_5A5A_5A5A) begin
                $display("FAIL restore_w1: addr=%h data=%h required 1 5a5a5a5a5a5a5a5a", wr_addr_q[wb + 1], wr_data_q[wb + 1]); n_fail++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (ir_viol != iv || in_ready !== 1'b0) begin
            $display("FAIL restore_inready: violations=%0d in_ready=%b required 0 0", ir_viol - iv, in_ready); n_fail++;
        end
        n_checks++;
        if (src_q.size() !== 0) begin
            $display("FAIL restore_consumed: %0d words left required 0", src_q.size()); n_fail++;
        end
        $display("restore idx=5 count=2: %0d writes", write_rises - wr);
    endtask

    task automatic test_hdr_mismatch();
        int wr;
        bit gd, ge;
        wr = write_rises;
        src_q.push_back(hdr(8'd6, 24'd2));
        src_q.push_back(64'h1111);
        src_q.push_back(64'h2222);
        do_start(1'b1, 8'd5, 24'd2);
        wait_end(50, gd, ge);
        n_checks++;
        if ({gd, ge} !== 2'b01) begin
            $display("FAIL hdr_err: done=%b error=%b required done=0 error=1", gd, ge); n_fail++;
        end
        n_checks++;
        if (write_rises - wr !== 0) begin
            $display("FAIL hdr_nowrite: got %0d strobes required 0", write_rises - wr); n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL hdr_idle: busy got %b required 0", busy); n_fail++;
        end
        src_q.delete();
        $display("restore header idx=6 vs 5: error raised");
    endtask

    task automatic test_zero_count();
        bit gd, ge;
        do_start(1'b0, 8'd1, 24'd0);
        @(negedge clk);
        n_checks++;
        if ({error, busy} !== 2'b10) begin
            $display("FAIL zero_count: error=%b busy=%b required 1 0", error, busy); n_fail++;
        end
        wait_end(5, gd, ge);
        $display("save count=0: immediate error");
    endtask

    task automatic test_timeout();
        int t_rise, t_err;
        bit seen, gd, ge;
        slave_en = 1'b0; out_ready = 1'b1;
        do_start(1'b0, 8'd1, 24'd2);
        seen = 1'b0; t_rise = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ss_read) begin seen = 1'b1; t_rise = cyc; end
        end
        wait_end(TIMEOUT + 20, gd, ge);
        t_err = cyc;
        n_checks++;
        if (!seen || !ge || t_err - t_rise !== TIMEOUT) begin
            $display("FAIL timeout_delay: strobe=%b error=%b delay=%0d required %0d", seen, ge, t_err - t_rise, TIMEOUT); n_fail++;
        end
        n_checks++;
        if (ss_read !== 1'b0) begin
            $display("FAIL timeout_strobe: ss_read got %b required 0", ss_read); n_fail++;
        end
        slave_en = 1'b1;
        $display("save no-ack: error after %0d cycles", t_err - t_rise);
    endtask

    task automatic test_reset_mid();
        int ob, rr;
        bit seen, gd, ge;
        logic [63:0] exp_w[$];
        slave_en = 1'b0; out_ready = 1'b1;
        do_start(1'b0, 8'd3, 24'd4);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ss_read) seen = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!seen || {busy, done, error, ss_read, ss_write, out_valid, in_ready} !== 7'b0 ||
            {ss_idx, ss_addr, ss_wdata, out_data} !== '0) begin
            $display("FAIL midreset_outputs: strobe_seen=%b ctrl=%b idx=%h addr=%h required all 0", seen,
                     {busy, done, error, ss_read, ss_write, out_valid, in_ready}, ss_idx, ss_addr); n_fail++;
        end
        slave_en = 1'b1;
        ob = out_q.size(); rr = read_rises;
        exp_w.push_back(hdr(8'd3, 24'd1));
        exp_w.push_back(slave_data(24'd0));
`ifdef SS_CHECKSUM_EN
        exp_w.push_back(slave_data(24'd0));
`endif
        do_start(1'b0, 8'd3, 24'd1);
        wait_end(100, gd, ge);
        n_checks++;
        if ({gd, ge} !== 2'b10 || read_rises - rr !== 1) begin
            $display("FAIL midreset_rerun: done=%b error=%b reads=%0d required 1 0 1", gd, ge, read_rises - rr); n_fail++;
        end
        n_checks++;
        if (out_q.size() - ob !== exp_w.size()) begin
            $display("FAIL midreset_words: got %0d required %0d", out_q.size() - ob, exp_w.size()); n_fail++;
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                n_checks++;
                if (out_q[ob + k] !== exp_w[k]) begin
                    $display("FAIL midreset_word%0d: got %h required %h", k, out_q[ob + k], exp_w[k]); n_fail++;
                end
            end
        end
        $display("reset mid-save, then save count=1: %0d stream words", out_q.size() - ob);
    endtask

    task automatic test_checksum();
`ifdef SS_CHECKSUM_EN
        bit gd, ge;
        src_q.push_back(hdr(8'd5, 24'd1));
        src_q.push_back(64'h1234);
        src_q.push_back(64'h1235);
        do_start(1'b1, 8'd5, 24'd1);
        wait_end(100, gd, ge);
        n_checks++;
        if ({gd, ge} !== 2'b01) begin
            $display("FAIL csum_bad: done=%b error=%b required 0 1", gd, ge); n_fail++;
        end
        src_q.delete();
        $display("restore with corrupted trailer: error raised");
`endif
    endtask

    initial begin
        test_reset();
        test_save_basic();
        test_backpressure();
        test_restore();
        test_hdr_mismatch();
        test_zero_count();
        test_timeout();
        test_reset_mid();
        test_checksum();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
